// File: rtl/userid_table_if.sv
// Bus between the ID searcher/enrollment client and the user-ID table.
// Valid/ready rule: enroll_req is a level held with enroll_userid stable until the one-cycle enroll_ack; remove_req is a single-cycle strobe taken only while busy=0.
interface userid_table_if #(
  parameter int ADDR_W = 4,
  parameter int ID_W   = 16
);
  logic [ADDR_W-1:0] address;
  logic [ID_W-1:0]   userid;
  logic              entry_valid;
  logic              enroll_req;
  logic [ID_W-1:0]   enroll_userid;
  logic              enroll_ack;
  logic [1:0]        enroll_status;
  logic [ADDR_W-1:0] enroll_slot;
  logic              remove_req;
  logic [ADDR_W-1:0] remove_slot;
  logic              busy;
  logic [ADDR_W:0]   occupancy;
  logic [1:0]        fsm_state;

  modport master (
    output address, enroll_req, enroll_userid, remove_req, remove_slot,
    input  userid, entry_valid, enroll_ack, enroll_status, enroll_slot,
           busy, occupancy, fsm_state
  );

  modport slave (
    input  address, enroll_req, enroll_userid, remove_req, remove_slot,
    output userid, entry_valid, enroll_ack, enroll_status, enroll_slot,
           busy, occupancy, fsm_state
  );
endinterface

// File: rtl/userid_table.sv
// Enrollable user-ID store: 2-cycle read port for the searcher, plus a scan/commit
// enrollment FSM and a remove strobe. Slot 0 is reserved and always reads empty.
module userid_table #(
  parameter int              ADDR_W        = 4,
  parameter int              ID_W          = 16,
  parameter logic [ID_W-1:0] EMPTY_PATTERN = {ID_W{1'b1}}
) (
  input logic           clk,
  input logic           reset,
  userid_table_if.slave bus
);
  localparam int                SLOTS     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(SLOTS - 1);
  localparam logic [1:0] ST_OK = 2'd0, ST_DUP = 2'd1, ST_FULL = 2'd2, ST_INVALID = 2'd3;

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, COMMIT = 2'd2, DONE = 2'd3} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   mem_q [SLOTS];
  logic [SLOTS-1:0]  occ_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ID_W-1:0]   userid_q;
  logic              valid_q;
  logic              ack_q, ack_d;
  logic [1:0]        status_q, status_d;
  logic [ADDR_W-1:0] slot_q, slot_d;
  logic [ADDR_W-1:0] scan_q, scan_d;
  logic              match_hit_q, match_hit_d;
  logic [ADDR_W-1:0] match_slot_q, match_slot_d;
  logic              free_hit_q, free_hit_d;
  logic [ADDR_W-1:0] free_slot_q, free_slot_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wr_en, rm_en;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    ack_d        = 1'b0;
    status_d     = status_q;
    slot_d       = slot_q;
    scan_d       = scan_q;
    match_hit_d  = match_hit_q;
    match_slot_d = match_slot_q;
    free_hit_d   = free_hit_q;
    free_slot_d  = free_slot_q;
    wr_en        = 1'b0;
    rm_en        = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A remove strobe takes the edge; a pending enroll_req is accepted afterwards.
        if (bus.remove_req) begin
          rm_en = (bus.remove_slot != '0) && occ_q[bus.remove_slot];
        end else if (bus.enroll_req) begin
          if (bus.enroll_userid == EMPTY_PATTERN) begin
            state_d  = DONE;
            ack_d    = 1'b1;
            status_d = ST_INVALID;
            slot_d   = '0;
          end else begin
            state_d      = SCAN;
            scan_d       = ADDR_W'(1);
            match_hit_d  = 1'b0;
            match_slot_d = '0;
            free_hit_d   = 1'b0;
            free_slot_d  = '0;
          end
        end
      end
      SCAN: begin
        if (occ_q[scan_q] && (mem_q[scan_q] == bus.enroll_userid) && !match_hit_q) begin
          match_hit_d  = 1'b1;
          match_slot_d = scan_q;
        end
        if (!occ_q[scan_q] && !free_hit_q) begin
          free_hit_d  = 1'b1;
          free_slot_d = scan_q;
        end
        if (scan_q == LAST_SLOT) state_d = COMMIT;
        else                     scan_d  = scan_q + ADDR_W'(1);
      end
      COMMIT: begin
        state_d = DONE;
        ack_d   = 1'b1;
        if (match_hit_q) begin
          status_d = ST_DUP;
          slot_d   = match_slot_q;
        end else if (!free_hit_q) begin
          status_d = ST_FULL;
          slot_d   = '0;
        end else begin
          status_d = ST_OK;
          slot_d   = free_slot_q;
          wr_en    = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (wr_en)      count_d = count_q + (ADDR_W+1)'(1);
    else if (rm_en) count_d = count_q - (ADDR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      occ_q        <= '0;
      addr_q       <= '0;
      userid_q     <= EMPTY_PATTERN;
      valid_q      <= 1'b0;
      ack_q        <= 1'b0;
      status_q     <= ST_OK;
      slot_q       <= '0;
      scan_q       <= '0;
      match_hit_q  <= 1'b0;
      match_slot_q <= '0;
      free_hit_q   <= 1'b0;
      free_slot_q  <= '0;
      count_q      <= '0;
    end else begin
      // Read samples the pre-edge table, so a same-edge commit/remove returns old data.
      addr_q       <= bus.address;
      userid_q     <= occ_q[addr_q] ? mem_q[addr_q] : EMPTY_PATTERN;
      valid_q      <= occ_q[addr_q];
      ack_q        <= ack_d;
      status_q     <= status_d;
      slot_q       <= slot_d;
      scan_q       <= scan_d;
      match_hit_q  <= match_hit_d;
      match_slot_q <= match_slot_d;
      free_hit_q   <= free_hit_d;
      free_slot_q  <= free_slot_d;
      count_q      <= count_d;
      if (wr_en) occ_q[free_slot_q] <= 1'b1;
      if (rm_en) occ_q[bus.remove_slot] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && wr_en) mem_q[free_slot_q] <= bus.enroll_userid;
  end

  assign bus.userid        = userid_q;
  assign bus.entry_valid   = valid_q;
  assign bus.enroll_ack    = ack_q;
  assign bus.enroll_status = status_q;
  assign bus.enroll_slot   = slot_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.occupancy     = count_q;
  assign bus.fsm_state     = state_q;
endmodule
